multi_channel_timer: RTL

MULTI_CHANNEL_TIMER -- requirements
Module: multi_channel_timer

---
 rtl/mct_pkg.sv | 27 ++
 rtl/mct_channel.sv | 101 ++++++++++
 rtl/multi_channel_timer.sv | 86 ++++++++
 3 files changed

// File: rtl/mct_pkg.sv
// rtl/mct_pkg.sv - register map, bit positions and shared types for multi_channel_timer
package mct_pkg;

    localparam logic [3:0] REG_STATUS   = 4'd0;
    localparam logic [3:0] REG_CONTROL  = 4'd1;
    localparam logic [3:0] REG_PERIOD0  = 4'd2;
    localparam logic [3:0] REG_SNAP0    = 4'd6;
    localparam logic [3:0] REG_PRESCALE = 4'd10;
    localparam logic [3:0] REG_PENDING  = 4'd11;

    localparam int STS_TIMEOUT = 0;
    localparam int STS_RUNNING = 1;
    localparam int CTL_START   = 2;
    localparam int CTL_STOP    = 3;

    typedef struct packed {
        logic stop;
        logic start;
        logic cont;
        logic ie;
    } mct_ctrl_t;

    function automatic logic [15:0] get_hw(input logic [63:0] v, input logic [1:0] idx);
        return v[{idx, 4'b0000} +: 16];
    endfunction

endpackage

// File: rtl/mct_channel.sv
// rtl/mct_channel.sv - one timer channel: prescaler, down counter, sticky timeout, snapshot
module mct_channel
    import mct_pkg::*;
#(
    parameter int          CNT_W          = 32,
    parameter int          PRE_W          = 8,
    parameter logic [63:0] DEFAULT_PERIOD = 64'h124F7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [3:0]       reg_sel,
    input  logic [15:0]      wdata,
    input  logic             pend_clr,
    output logic [1:0]       status,
    output mct_ctrl_t        ctrl,
    output logic [63:0]      period_ext,
    output logic [63:0]      snapshot_ext,
    output logic [PRE_W-1:0] prescale,
    output logic             irq
);

    localparam int NHW = CNT_W / 16;
    localparam logic [CNT_W-1:0] DEF = DEFAULT_PERIOD[CNT_W-1:0];

    logic [CNT_W-1:0] period, counter, snapshot, period_wr;
    logic [PRE_W-1:0] psc;
    logic running, timeout, zero_q;
    logic per_wr, snap_wr, ctl_wr, clr, tick, at_zero, event_to;

    always_comb begin
        period_wr = period;
        per_wr    = 1'b0;
        snap_wr   = 1'b0;
        for (int h = 0; h < NHW; h++) begin
            if (wr_en && reg_sel == 4'(REG_PERIOD0 + h)) begin
                period_wr[h*16 +: 16] = wdata;
                per_wr = 1'b1;
            end
            if (wr_en && reg_sel == 4'(REG_SNAP0 + h))
                snap_wr = 1'b1;
        end
    end

    assign ctl_wr   = wr_en && reg_sel == REG_CONTROL;
    assign clr      = (wr_en && reg_sel == REG_STATUS) || pend_clr;
    assign at_zero  = counter == '0;
    assign tick     = running && (psc >= prescale);
    // zero_q starts at 1 so a reset load can never look like a fresh zero crossing
    assign event_to = at_zero && !zero_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            period   <= DEF;
            counter  <= DEF;
            snapshot <= '0;
            psc      <= '0;
            prescale <= '0;
            ctrl     <= '0;
            running  <= 1'b0;
            timeout  <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            zero_q  <= at_zero;
            timeout <= (timeout && !clr) || event_to;
            if (snap_wr)
                snapshot <= counter;
            if (ctl_wr)
                ctrl <= mct_ctrl_t'(wdata[3:0]);
            if (wr_en && reg_sel == REG_PRESCALE)
                prescale <= wdata[PRE_W-1:0];
            if (per_wr) begin
                period  <= period_wr;
                counter <= period_wr;
                psc     <= '0;
                running <= 1'b0;
            end else begin
                if (!running || tick)
                    psc <= '0;
                else
                    psc <= psc + 1'b1;
                // a one-shot channel parks at zero instead of reloading
                if (tick && !(at_zero && !ctrl.cont))
                    counter <= at_zero ? period : counter - 1'b1;
                if (ctl_wr && wdata[CTL_START])
                    running <= 1'b1;
                else if (ctl_wr && wdata[CTL_STOP])
                    running <= 1'b0;
                else if (running && at_zero && !ctrl.cont)
                    running <= 1'b0;
            end
        end
    end

    assign status[STS_RUNNING] = running;
    assign status[STS_TIMEOUT] = timeout;
    assign period_ext   = 64'(period);
    assign snapshot_ext = 64'(snapshot);
    assign irq          = timeout && ctrl.ie;

endmodule

// File: rtl/multi_channel_timer.sv
// rtl/multi_channel_timer.sv - register decode, read mux and interrupt merge over timer channels
module multi_channel_timer
    import mct_pkg::*;
#(
    parameter int          NUM_CH         = 4,
    parameter int          CNT_W          = 32,
    parameter int          PRE_W          = 8,
    parameter logic [63:0] DEFAULT_PERIOD = 64'h124F7
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [$clog2(NUM_CH)+3:0]  address,
    input  logic                       chipselect,
    input  logic                       write_n,
    input  logic [15:0]                writedata,
    output logic [15:0]                readdata,
    output logic                       irq,
    output logic [NUM_CH-1:0]          irq_vec
);

    localparam int AW = $clog2(NUM_CH) + 4;

    logic          wr, pend_wr;
    logic [3:0]    reg_sel;
    logic [AW-1:0] ch_sel;
    logic [15:0]   rd_next;

    logic [1:0]       status   [NUM_CH];
    mct_ctrl_t        ctrl_q   [NUM_CH];
    logic [63:0]      per_ext  [NUM_CH];
    logic [63:0]      snap_ext [NUM_CH];
    logic [PRE_W-1:0] pre      [NUM_CH];

    assign wr      = chipselect && !write_n;
    assign reg_sel = address[3:0];
    assign ch_sel  = address >> 4;
    assign pend_wr = wr && ch_sel == '0 && reg_sel == REG_PENDING;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        mct_channel #(
            .CNT_W          (CNT_W),
            .PRE_W          (PRE_W),
            .DEFAULT_PERIOD (DEFAULT_PERIOD)
        ) u_ch (
            .clk          (clk),
            .reset        (reset),
            .wr_en        (wr && ch_sel == AW'(i)),
            .reg_sel      (reg_sel),
            .wdata        (writedata),
            .pend_clr     (pend_wr && writedata[i]),
            .status       (status[i]),
            .ctrl         (ctrl_q[i]),
            .period_ext   (per_ext[i]),
            .snapshot_ext (snap_ext[i]),
            .prescale     (pre[i]),
            .irq          (irq_vec[i])
        );
    end

    assign irq = |irq_vec;

    always_comb begin
        rd_next = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == AW'(i)) begin
                case (reg_sel)
                    REG_STATUS:             rd_next = 16'(status[i]);
                    REG_CONTROL:            rd_next = 16'(ctrl_q[i]);
                    4'd2, 4'd3, 4'd4, 4'd5: rd_next = get_hw(per_ext[i], 2'(reg_sel - REG_PERIOD0));
                    4'd6, 4'd7, 4'd8, 4'd9: rd_next = get_hw(snap_ext[i], 2'(reg_sel - REG_SNAP0));
                    REG_PRESCALE:           rd_next = 16'(pre[i]);
                    REG_PENDING:            if (i == 0) rd_next = 16'(irq_vec);
                    default:                rd_next = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            readdata <= '0;
        else
            readdata <= rd_next;
    end

endmodule
